// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request feeding the IF/ID register. Zero-wait capable.
// Stall parks one fetched word in a holding buffer; a redirect discards in-flight data and flushes IF/ID.
module ifetch #(
  parameter int unsigned       INSWIDTH = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESETPC  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect,
  input  logic [AWIDTH-1:0]   target,
  output logic                imemreq,
  output logic [AWIDTH-1:0]   imemaddr,
  input  logic                imemack,
  input  logic [INSWIDTH-1:0] imemdata,
  output logic [INSWIDTH-1:0] insout,
  output logic [AWIDTH-1:0]   pcnextout,
  output logic                wr,
  output logic                flush,
  output logic [AWIDTH-1:0]   pc
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [INSWIDTH-1:0] ins;
    logic [AWIDTH-1:0]   pcn;
  } hold_t;

  localparam logic [AWIDTH-1:0] INC = AWIDTH'(4);

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   reqaddr_q, reqaddr_d;
  hold_t               buf_q, buf_d;
  logic [AWIDTH-1:0]   req_inc;
  logic                ack;

  assign imemaddr = reqaddr_q;
  assign pc       = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    reqaddr_d = reqaddr_q;
    buf_d     = buf_q;
    wr        = 1'b0;
    flush     = 1'b0;
    insout    = buf_q.ins;
    pcnextout = buf_q.pcn;
    req_inc   = reqaddr_q + INC;
    imemreq   = (state_q == FETCH) || (state_q == DRAIN);
    ack       = imemreq && imemack;

    // Redirect wins everywhere; flush is held low while reset is asserted.
    if (redirect) begin
      flush = rst_n;
      pc_d  = target;
    end

    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        reqaddr_d = pc_d;
      end
      FETCH: begin
        pcnextout = req_inc;
        if (ack) begin
          insout = imemdata;
        end
        if (redirect) begin
          if (ack) begin
            reqaddr_d = target;
          end else begin
            state_d = DRAIN;
          end
        end else if (ack) begin
          pc_d = req_inc;
          if (stall) begin
            buf_d   = '{ins: imemdata, pcn: req_inc};
            state_d = HOLD;
          end else begin
            wr        = 1'b1;
            reqaddr_d = req_inc;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          reqaddr_d = target;
          state_d   = FETCH;
        end else if (!stall) begin
          wr        = 1'b1;
          reqaddr_d = pc_q;
          state_d   = FETCH;
        end
      end
      DRAIN: begin
        // The stale response only retires the old request; fetch resumes at the latest pc.
        if (ack) begin
          reqaddr_d = pc_d;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESETPC;
      reqaddr_q <= RESETPC;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      reqaddr_q <= reqaddr_d;
      buf_q     <= buf_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a transaction-level fetch model.
module tb_ifetch;

  localparam logic [31:0] RPC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imemack;
  logic [31:0] target;
  logic        imemreq, wr, flush;
  logic [31:0] imemaddr, imemdata, insout, pcnextout, pc;

  ifetch #(.INSWIDTH(32), .AWIDTH(32), .RESETPC(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .redirect  (redirect),
    .target    (target),
    .imemreq   (imemreq),
    .imemaddr  (imemaddr),
    .imemack   (imemack),
    .imemdata  (imemdata),
    .insout    (insout),
    .pcnextout (pcnextout),
    .wr        (wr),
    .flush     (flush),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_9E01;
  endfunction

  assign imemdata = mem_word(imemaddr);

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pcn;
  } ent_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_wr    = 0;
  ent_t        q[$];
  logic [31:0] pc_m;
  logic        discard_m, idle_m;
  logic        prev_wait;
  logic [31:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle-level reference: program-order write stream, pc, request gating, discard of stale data.
  task automatic eval();
    ent_t e;
    logic ack_x;
    logic exp_wr;
    chk("pc", pc, pc_m);
    chk("imemreq", {31'b0, imemreq}, {31'b0, (!idle_m && q.size() == 0)});
    chk("flush", {31'b0, flush}, {31'b0, redirect});
    if (prev_wait) chk("addr_stable", imemaddr, prev_addr);
    ack_x = imemreq && imemack;
    if (redirect) begin
      chk("wr_redirect", {31'b0, wr}, 32'd0);
      q.delete();
      discard_m = imemreq && !imemack;
      pc_m      = target;
    end else begin
      if (ack_x) begin
        if (discard_m) begin
          discard_m = 1'b0;
        end else begin
          chk("fetch_addr", imemaddr, pc_m);
          e.ins = mem_word(pc_m);
          e.pcn = pc_m + 32'd4;
          q.push_back(e);
          pc_m = pc_m + 32'd4;
        end
      end
      exp_wr = !stall && (q.size() > 0);
      chk("wr", {31'b0, wr}, {31'b0, exp_wr});
      if (wr && q.size() > 0) begin
        e = q.pop_front();
        chk("insout", insout, e.ins);
        chk("pcnextout", pcnextout, e.pcn);
        n_wr++;
      end
    end
    prev_wait = imemreq && !imemack;
    prev_addr = imemaddr;
    idle_m    = 1'b0;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] tg, input logic ak);
    stall    = st;
    redirect = rd;
    target   = tg;
    imemack  = ak;
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b1;
    target   = 32'h1234_5670;
    imemack  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imemreq", {31'b0, imemreq}, 32'd0);
    chk("rst_wr", {31'b0, wr}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_imemaddr", imemaddr, RPC);
    q.delete();
    pc_m      = RPC;
    discard_m = 1'b0;
    idle_m    = 1'b1;
    prev_wait = 1'b0;
    prev_addr = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    logic        st, rd, ak;
    logic [31:0] tg;
    do_reset();

    // Zero-wait stream across the address wrap.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Stall capture with stall held for three cycles.
    step(1'b0, 1'b1, 32'h10, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Redirect while a request to 0x20 waits for its ack.
    step(1'b0, 1'b1, 32'h20, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Redirect coinciding with an ack.
    step(1'b0, 1'b1, 32'h30, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom % 10) < 3;
      rd = ($urandom % 100) < 8;
      ak = ($urandom % 10) < 6;
      tg = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 1023)) << 2);
      step(st, rd, tg, ak);
    end
    chk("progress", {31'b0, (n_wr > 200)}, 32'd1);

    // Reset asserted while the request to 0x40 is outstanding.
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wait_addr", imemaddr, 32'h40);
    chk("wait_req", {31'b0, imemreq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imemreq}, 32'd0);
    chk("midrst_wr", {31'b0, wr}, 32'd0);
    chk("midrst_pc", pc, RPC);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter INSWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter AWIDTH, default 32, address width.
REQ-003 SHALL have parameter RESETPC, default 0, first fetch address.
REQ-004 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: stall  in  1  decode holds IF/ID; no new instruction may be written.
REQ-007 SHALL have ports: redirect  in  1  taken branch/jump; refetch from target.
REQ-008 SHALL have ports: target  in  AWIDTH  redirect address.
REQ-009 SHALL have ports: imemreq  out  1; imemaddr  out  AWIDTH; imemack  in  1; imemdata  in  INSWIDTH (instruction memory request/acknowledge).
REQ-010 SHALL have ports: insout  out  INSWIDTH; pcnextout  out  AWIDTH (IF/ID instruction and PC+4 inputs).
REQ-011 SHALL have ports: wr  out  1; flush  out  1 (IF/ID write and flush, active high).
REQ-012 SHALL have ports: pc  out  AWIDTH  next fetch address (debug).

Function
REQ-013 SHALL implement states IDLE, FETCH, HOLD, DRAIN.
REQ-014 Memory handshake SHALL be: transfer completes on a rising edge with imemreq=1 and imemack=1; imemack with imemreq=0 ignored; zero-wait (ack in the request cycle) legal.
REQ-015 imemaddr SHALL be taken from a request-address register and stay stable from assertion of imemreq until its completing edge.
REQ-016 imemreq SHALL be 1 in FETCH and DRAIN, 0 in IDLE and HOLD.
REQ-017 IDLE: next edge -> FETCH with request address = pc; redirect in IDLE loads pc=target, flush=1.
REQ-018 FETCH, ack, no stall, no redirect: wr=1 combinationally, insout=imemdata, pcnextout=reqaddr+4; pc and reqaddr <= reqaddr+4; stay FETCH.
REQ-019 FETCH, ack, stall, no redirect: wr=0; imemdata and reqaddr+4 captured into holding buffer; pc <= reqaddr+4; -> HOLD.
REQ-020 HOLD: insout/pcnextout SHALL come from buffer; wr = !stall; when stall=0, reqaddr <= pc and -> FETCH.
REQ-021 Redirect SHALL have priority over all other events: flush=1, wr=0, pc <= target in that cycle.
REQ-022 Redirect in FETCH with ack same cycle: response discarded, reqaddr <= target, stay FETCH.
REQ-023 Redirect in FETCH without ack: -> DRAIN; outstanding request kept at old address until ack; response discarded.
REQ-024 DRAIN on ack: reqaddr <= pc, -> FETCH; wr=0 throughout DRAIN; a further redirect in DRAIN updates pc only.
REQ-025 Redirect in HOLD: buffer discarded, reqaddr <= target, -> FETCH.
REQ-026 Address arithmetic SHALL be modulo 2^AWIDTH; increment is 4; wrap from 2^AWIDTH-4 to 0 silent.
REQ-027 insout and pcnextout SHALL be don't-care when wr=0, but SHALL not contain X in FETCH/HOLD.
REQ-028 At most one instruction SHALL be written to IF/ID per memory transfer; none lost or duplicated under stall.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, pc=reqaddr=RESETPC, buffer=0, imemreq=0, wr=0, flush=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer; first request after release is to RESETPC, one cycle after release.

Verification
REQ-031 Zero-wait stream: release reset, imemack tied 1 -> imemaddr 0,4,8,... on consecutive cycles, wr=1 each FETCH cycle, pcnextout=imemaddr+4.
REQ-032 Stall capture: ack at addr 0x10 with stall=1 for 3 cycles -> wr=0, imemreq=0 for 3 cycles, then wr=1, insout=captured word, pcnextout=0x14, next request 0x14.
REQ-033 Redirect during wait: request 0x20 pending, redirect target 0x100 -> flush=1 one cycle, imemaddr stays 0x20 until ack, that data not written, next request 0x100.
REQ-034 Redirect with same-cycle ack at 0x30, target 0x200 -> flush=1, wr=0, next imemaddr 0x200.
REQ-035 Wrap: RESETPC=0xFFFFFFFC -> second request address 0x00000000, pcnextout=0x00000000 on first write.
REQ-036 Reset mid-wait at 0x40 -> imemreq=0 immediately; after release, IDLE one cycle then request RESETPC.
